// File: rtl/cluster_boot_sequencer.sv
// Host-side boot sequencer: waits BootDelay cycles, writes the entry point to the
// cluster scratch register, then wakes all harts via CLINT set. Optional: SNITCH_BOOT_RETRY_EN.
module cluster_boot_sequencer #(
    parameter int unsigned             NrCores        = 9,
    parameter int unsigned             AddrWidth      = 48,
    parameter int unsigned             BootDelay      = 300,
    parameter logic [AddrWidth-1:0]    ScratchOffset  = AddrWidth'(48'h0004_0180),
    parameter logic [AddrWidth-1:0]    ClintSetOffset = AddrWidth'(48'h0004_0030),
    parameter int unsigned             MaxRetries     = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [AddrWidth-1:0] cluster_base_addr_i,
    input  logic [31:0]          entry_point_i,
    output logic                 req_valid_o,
    input  logic                 req_ready_i,
    output logic [AddrWidth-1:0] req_addr_o,
    output logic [63:0]          req_data_o,
    output logic [7:0]           req_strb_o,
    input  logic                 rsp_valid_i,
    output logic                 rsp_ready_o,
    input  logic [1:0]           rsp_resp_i,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int unsigned BOOT_DLY = (BootDelay == 0) ? 1 : BootDelay;
    localparam int unsigned CNT_W    = $clog2(BOOT_DLY + 1);
    localparam int unsigned RETRY_W  = (MaxRetries < 1) ? 1 : $clog2(MaxRetries + 1);
    localparam logic [31:0] MASK32   = 32'((64'd1 << NrCores) - 64'd1);
`ifdef SNITCH_BOOT_RETRY_EN
    localparam bit          RETRY_EN = 1'b1;
`else
    localparam bit          RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_ENT_REQ = 3'd1,
        S_ENT_RSP = 3'd2,
        S_CLI_REQ = 3'd3,
        S_CLI_RSP = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    state_e               r_state, w_state_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    logic [RETRY_W-1:0]   r_retry, w_retry_nxt;
    logic                 r_req_valid, w_req_valid_nxt;
    logic [AddrWidth-1:0] r_req_addr, w_req_addr_nxt;
    logic [63:0]          r_req_data, w_req_data_nxt;
    logic [7:0]           r_req_strb, w_req_strb_nxt;
    logic                 r_rsp_ready, w_rsp_ready_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_err, w_err_nxt;

    logic [AddrWidth-1:0] w_ent_addr;
    logic [AddrWidth-1:0] w_cli_addr;
    logic                 w_rsp_err;
    logic                 w_retry;

    // Address sums wrap naturally at AddrWidth bits.
    assign w_ent_addr = cluster_base_addr_i + ScratchOffset;
    assign w_cli_addr = cluster_base_addr_i + ClintSetOffset;
    assign w_rsp_err  = (rsp_resp_i == 2'd2) || (rsp_resp_i == 2'd3);
    assign w_retry    = RETRY_EN && w_rsp_err && (r_retry != RETRY_W'(MaxRetries));

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_retry_nxt     = r_retry;
        w_req_valid_nxt = r_req_valid;
        w_req_addr_nxt  = r_req_addr;
        w_req_data_nxt  = r_req_data;
        w_req_strb_nxt  = r_req_strb;
        w_rsp_ready_nxt = r_rsp_ready;
        w_done_nxt      = r_done;
        w_err_nxt       = r_err;

        case (r_state)
            S_WAIT: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (r_cnt == CNT_W'(BOOT_DLY - 1)) begin
                    w_state_nxt     = S_ENT_REQ;
                    w_req_valid_nxt = 1'b1;
                    w_req_addr_nxt  = w_ent_addr;
                    w_req_data_nxt  = {entry_point_i, entry_point_i};
                    w_req_strb_nxt  = w_ent_addr[2] ? 8'hF0 : 8'h0F;
                    w_retry_nxt     = '0;
                end
            end
            S_ENT_REQ: begin
                if (req_ready_i) begin
                    w_state_nxt     = S_ENT_RSP;
                    w_req_valid_nxt = 1'b0;
                    w_rsp_ready_nxt = 1'b1;
                end
            end
            S_ENT_RSP: begin
                if (rsp_valid_i) begin
                    w_rsp_ready_nxt = 1'b0;
                    w_req_valid_nxt = 1'b1;
                    if (w_retry) begin
                        // Address/data/strobe registers still hold the original write.
                        w_state_nxt = S_ENT_REQ;
                        w_retry_nxt = r_retry + RETRY_W'(1);
                    end else begin
                        w_state_nxt    = S_CLI_REQ;
                        w_retry_nxt    = '0;
                        w_err_nxt      = r_err | w_rsp_err;
                        w_req_addr_nxt = w_cli_addr;
                        w_req_data_nxt = {MASK32, MASK32};
                        w_req_strb_nxt = w_cli_addr[2] ? 8'hF0 : 8'h0F;
                    end
                end
            end
            S_CLI_REQ: begin
                if (req_ready_i) begin
                    w_state_nxt     = S_CLI_RSP;
                    w_req_valid_nxt = 1'b0;
                    w_rsp_ready_nxt = 1'b1;
                end
            end
            S_CLI_RSP: begin
                if (rsp_valid_i) begin
                    w_rsp_ready_nxt = 1'b0;
                    if (w_retry) begin
                        w_state_nxt     = S_CLI_REQ;
                        w_req_valid_nxt = 1'b1;
                        w_retry_nxt     = r_retry + RETRY_W'(1);
                    end else begin
                        w_state_nxt = S_DONE;
                        w_retry_nxt = '0;
                        w_done_nxt  = 1'b1;
                        w_err_nxt   = r_err | w_rsp_err;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_DONE;
            end
            default: begin
                w_state_nxt = S_WAIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_WAIT;
            r_cnt       <= '0;
            r_retry     <= '0;
            r_req_valid <= 1'b0;
            r_req_addr  <= '0;
            r_req_data  <= '0;
            r_req_strb  <= '0;
            r_rsp_ready <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_retry     <= w_retry_nxt;
            r_req_valid <= w_req_valid_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_req_data  <= w_req_data_nxt;
            r_req_strb  <= w_req_strb_nxt;
            r_rsp_ready <= w_rsp_ready_nxt;
            r_done      <= w_done_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign req_valid_o = r_req_valid;
    assign req_addr_o  = r_req_addr;
    assign req_data_o  = r_req_data;
    assign req_strb_o  = r_req_strb;
    assign rsp_ready_o = r_rsp_ready;
    assign done_o      = r_done;
    assign err_o       = r_err;

endmodule

// File: tb/tb_cluster_boot_sequencer.sv
// Directed bench for cluster_boot_sequencer: default instance (a_*) plus a
// BootDelay=0 / ScratchOffset=4 instance (b_*) for wrap and strobe cases.
module tb_cluster_boot_sequencer;

    localparam logic [47:0] ENT_A = 48'h0000_1004_0180;
    localparam logic [47:0] CLI_A = 48'h0000_1004_0030;
    localparam logic [63:0] MASKD = 64'h0000_01FF_0000_01FF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_rst, a_req_ready, a_rsp_valid, a_req_valid, a_rsp_ready, a_done, a_err;
    logic [47:0] a_base, a_req_addr;
    logic [31:0] a_entry;
    logic [1:0]  a_rsp_resp;
    logic [63:0] a_req_data;
    logic [7:0]  a_req_strb;

    logic        b_rst, b_req_ready, b_rsp_valid, b_req_valid, b_rsp_ready, b_done, b_err;
    logic [47:0] b_base, b_req_addr;
    logic [31:0] b_entry;
    logic [1:0]  b_rsp_resp;
    logic [63:0] b_req_data;
    logic [7:0]  b_req_strb;

    cluster_boot_sequencer u_dut_a (
        .clk_i(clk), .rst_i(a_rst), .cluster_base_addr_i(a_base), .entry_point_i(a_entry),
        .req_valid_o(a_req_valid), .req_ready_i(a_req_ready), .req_addr_o(a_req_addr),
        .req_data_o(a_req_data), .req_strb_o(a_req_strb), .rsp_valid_i(a_rsp_valid),
        .rsp_ready_o(a_rsp_ready), .rsp_resp_i(a_rsp_resp), .done_o(a_done), .err_o(a_err)
    );

    cluster_boot_sequencer #(.BootDelay(0), .ScratchOffset(48'h4)) u_dut_b (
        .clk_i(clk), .rst_i(b_rst), .cluster_base_addr_i(b_base), .entry_point_i(b_entry),
        .req_valid_o(b_req_valid), .req_ready_i(b_req_ready), .req_addr_o(b_req_addr),
        .req_data_o(b_req_data), .req_strb_o(b_req_strb), .rsp_valid_i(b_rsp_valid),
        .rsp_ready_o(b_rsp_ready), .rsp_resp_i(b_rsp_resp), .done_o(b_done), .err_o(b_err)
    );

    // Returns on a falling edge with reset just released: that is cycle 0.
    task automatic reset_a();
        a_rst = 1'b1;
        repeat (2) @(negedge clk);
        a_rst = 1'b0;
    endtask

    task automatic reset_b();
        b_rst = 1'b1;
        repeat (2) @(negedge clk);
        b_rst = 1'b0;
    endtask

    task automatic test_reset();
        a_base = 48'h1000_0000; a_entry = 32'h8000_0000;
        a_req_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_resp = 2'd0;
        reset_a();
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", a_req_valid); end
        checks++; if (a_rsp_ready !== 1'b0) begin errors++; $display("FAIL rst_rsp_ready: got %b exp 0", a_rsp_ready); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", a_done); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", a_err); end
        checks++; if (a_req_addr !== 48'h0) begin errors++; $display("FAIL rst_addr: got %h exp 0", a_req_addr); end
        checks++; if (a_req_data !== 64'h0) begin errors++; $display("FAIL rst_data: got %h exp 0", a_req_data); end
        checks++; if (a_req_strb !== 8'h0) begin errors++; $display("FAIL rst_strb: got %h exp 0", a_req_strb); end
    endtask

    task automatic test_zero_latency();
        a_base = 48'h1000_0000; a_entry = 32'h8000_0000;
        a_req_ready = 1'b1; a_rsp_valid = 1'b1; a_rsp_resp = 2'd0;
        reset_a();
        repeat (299) @(negedge clk);
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL zl_valid_299: got %b exp 0", a_req_valid); end
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b1) begin errors++; $display("FAIL zl_valid_300: got %b exp 1", a_req_valid); end
        checks++; if (a_req_addr !== ENT_A) begin errors++; $display("FAIL zl_ent_addr: got %h exp %h", a_req_addr, ENT_A); end
        checks++; if (a_req_data !== 64'h8000_0000_8000_0000) begin errors++; $display("FAIL zl_ent_data: got %h exp 8000000080000000", a_req_data); end
        checks++; if (a_req_strb !== 8'h0F) begin errors++; $display("FAIL zl_ent_strb: got %h exp 0f", a_req_strb); end
        @(negedge clk);
        checks++; if (a_rsp_ready !== 1'b1 || a_req_valid !== 1'b0) begin errors++; $display("FAIL zl_ent_rsp: got rdy %b vld %b exp 1 0", a_rsp_ready, a_req_valid); end
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b1) begin errors++; $display("FAIL zl_cli_valid: got %b exp 1", a_req_valid); end
        checks++; if (a_req_addr !== CLI_A) begin errors++; $display("FAIL zl_cli_addr: got %h exp %h", a_req_addr, CLI_A); end
        checks++; if (a_req_data !== MASKD) begin errors++; $display("FAIL zl_cli_data: got %h exp %h", a_req_data, MASKD); end
        checks++; if (a_req_strb !== 8'h0F) begin errors++; $display("FAIL zl_cli_strb: got %h exp 0f", a_req_strb); end
        @(negedge clk);
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL zl_done_303: got %b exp 0", a_done); end
        @(negedge clk);
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL zl_done_304: got %b exp 1", a_done); end
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL zl_err: got %b exp 0", a_err); end
        checks++; if (a_req_valid !== 1'b0 || a_rsp_ready !== 1'b0) begin errors++; $display("FAIL zl_done_idle: got vld %b rdy %b exp 0 0", a_req_valid, a_rsp_ready); end
    endtask

    task automatic test_backpressure();
        int xfers;
        xfers = 0;
        a_base = 48'h1000_0000; a_entry = 32'hA5A5_0001;
        a_req_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_resp = 2'd0;
        reset_a();
        repeat (300) @(negedge clk);
        a_entry = 32'hDEAD_BEEF;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (a_req_valid !== 1'b1 || a_req_addr !== ENT_A || a_req_data !== 64'hA5A5_0001_A5A5_0001 || a_req_strb !== 8'h0F) begin
                errors++; $display("FAIL bp_stable_%0d: got v %b a %h d %h s %h exp 1 %h a5a50001a5a50001 0f", i, a_req_valid, a_req_addr, a_req_data, a_req_strb, ENT_A);
            end
            if (i == 5) a_req_ready = 1'b1;
            if (a_req_valid && a_req_ready && a_req_addr == ENT_A) xfers++;
            @(negedge clk);
        end
        checks++; if (a_req_valid !== 1'b0 || a_rsp_ready !== 1'b1) begin errors++; $display("FAIL bp_rsp_phase: got vld %b rdy %b exp 0 1", a_req_valid, a_rsp_ready); end
        a_rsp_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (a_req_valid && a_req_ready && a_req_addr == ENT_A) xfers++;
            @(negedge clk);
        end
        checks++; if (xfers !== 1) begin errors++; $display("FAIL bp_one_xfer: got %0d exp 1", xfers); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b exp 1", a_done); end
    endtask

    task automatic test_rsp_ignored();
        a_base = 48'h1000_0000; a_entry = 32'h8000_0000;
        a_req_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_resp = 2'd0;
        reset_a();
        repeat (100) @(negedge clk);
        a_rsp_valid = 1'b1; a_rsp_resp = 2'd2;
        @(negedge clk);
        checks++; if (a_rsp_ready !== 1'b0) begin errors++; $display("FAIL ign_wait_rdy: got %b exp 0", a_rsp_ready); end
        a_rsp_valid = 1'b0;
        repeat (198) @(negedge clk);
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL ign_valid_299: got %b exp 0", a_req_valid); end
        @(negedge clk);
        a_rsp_valid = 1'b1;
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b1 || a_rsp_ready !== 1'b0) begin errors++; $display("FAIL ign_req_hold: got vld %b rdy %b exp 1 0", a_req_valid, a_rsp_ready); end
        a_rsp_valid = 1'b0; a_rsp_resp = 2'd0; a_req_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (a_rsp_ready !== 1'b1 || a_req_valid !== 1'b0) begin errors++; $display("FAIL ign_rsp_wait: got rdy %b vld %b exp 1 0", a_rsp_ready, a_req_valid); end
        a_rsp_valid = 1'b1;
        @(negedge clk);
        checks++; if (a_req_addr !== CLI_A || a_req_valid !== 1'b1) begin errors++; $display("FAIL ign_cli: got a %h v %b exp %h 1", a_req_addr, a_req_valid, CLI_A); end
        repeat (2) @(negedge clk);
        checks++; if (a_done !== 1'b1 || a_err !== 1'b0) begin errors++; $display("FAIL ign_done: got done %b err %b exp 1 0", a_done, a_err); end
    endtask

    task automatic test_reset_mid();
        a_base = 48'h1000_0000; a_entry = 32'h8000_0000;
        a_req_ready = 1'b1; a_rsp_valid = 1'b1; a_rsp_resp = 2'd0;
        reset_a();
        repeat (303) @(negedge clk);
        checks++; if (a_rsp_ready !== 1'b1) begin errors++; $display("FAIL mid_in_cli_rsp: got %b exp 1", a_rsp_ready); end
        a_rst = 1'b1;
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b0 || a_rsp_ready !== 1'b0 || a_done !== 1'b0 || a_req_addr !== 48'h0) begin
            errors++; $display("FAIL mid_cleared: got v %b r %b d %b a %h exp 0 0 0 0", a_req_valid, a_rsp_ready, a_done, a_req_addr);
        end
        a_rst = 1'b0;
        repeat (299) @(negedge clk);
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_299: got %b exp 0", a_req_valid); end
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b1) begin errors++; $display("FAIL mid_valid_300: got %b exp 1", a_req_valid); end
        repeat (4) @(negedge clk);
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL mid_done: got %b exp 1", a_done); end
    endtask

    task automatic test_error();
        a_base = 48'h1000_0000; a_entry = 32'h8000_0000;
        a_req_ready = 1'b1; a_rsp_valid = 1'b1; a_rsp_resp = 2'b10;
        reset_a();
        repeat (300) @(negedge clk);
`ifdef SNITCH_BOOT_RETRY_EN
        repeat (6) @(negedge clk);
        checks++; if (a_req_valid !== 1'b1 || a_req_addr !== ENT_A || a_err !== 1'b0) begin
            errors++; $display("FAIL err_retry4: got v %b a %h e %b exp 1 %h 0", a_req_valid, a_req_addr, a_err, ENT_A);
        end
        repeat (2) @(negedge clk);
`else
        @(negedge clk);
        checks++; if (a_err !== 1'b0) begin errors++; $display("FAIL err_early: got %b exp 0", a_err); end
        @(negedge clk);
`endif
        checks++; if (a_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b exp 1", a_err); end
        checks++; if (a_req_valid !== 1'b1 || a_req_addr !== CLI_A) begin errors++; $display("FAIL err_cli: got v %b a %h exp 1 %h", a_req_valid, a_req_addr, CLI_A); end
        a_rsp_resp = 2'd0;
        repeat (2) @(negedge clk);
        checks++; if (a_done !== 1'b1 || a_err !== 1'b1) begin errors++; $display("FAIL err_done: got done %b err %b exp 1 1", a_done, a_err); end
    endtask

    task automatic test_wrap();
        b_base = 48'hFFFF_FFFF_FFFC; b_entry = 32'h1234_5678;
        b_req_ready = 1'b1; b_rsp_valid = 1'b1; b_rsp_resp = 2'd0;
        reset_b();
        checks++; if (b_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid_0: got %b exp 0", b_req_valid); end
        @(negedge clk);
        checks++; if (b_req_valid !== 1'b1 || b_req_addr !== 48'h0 || b_req_strb !== 8'h0F) begin
            errors++; $display("FAIL wrap_zero: got v %b a %h s %h exp 1 0 0f", b_req_valid, b_req_addr, b_req_strb);
        end
        checks++; if (b_req_data !== 64'h1234_5678_1234_5678) begin errors++; $display("FAIL wrap_data: got %h exp 1234567812345678", b_req_data); end
        b_rst = 1'b1;
        b_base = 48'hFFFF_FFFF_FFF0;
        reset_b();
        @(negedge clk);
        checks++; if (b_req_addr !== 48'hFFFF_FFFF_FFF4 || b_req_strb !== 8'hF0) begin
            errors++; $display("FAIL wrap_hi_strb: got a %h s %h exp fffffffffff4 f0", b_req_addr, b_req_strb);
        end
        repeat (2) @(negedge clk);
        checks++; if (b_req_addr !== 48'h0000_0004_0020 || b_req_strb !== 8'h0F) begin
            errors++; $display("FAIL wrap_cli: got a %h s %h exp 000000040020 0f", b_req_addr, b_req_strb);
        end
        repeat (2) @(negedge clk);
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b exp 1", b_done); end
    endtask

    initial begin
        a_rst = 1'b1; a_base = '0; a_entry = '0; a_req_ready = 1'b0; a_rsp_valid = 1'b0; a_rsp_resp = 2'd0;
        b_rst = 1'b1; b_base = '0; b_entry = '0; b_req_ready = 1'b0; b_rsp_valid = 1'b0; b_rsp_resp = 2'd0;
        test_reset();
        test_zero_latency();
        test_backpressure();
        test_rsp_ignored();
        test_reset_mid();
        test_error();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
